// File: rtl/spi_mem_pkg.sv
// Shared definitions for the SPI command/data memory stage: opcodes and FSM states.
package spi_mem_pkg;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  typedef enum logic {
    IDLE    = 1'b0,
    RD_HOLD = 1'b1
  } state_t;

endpackage

// File: rtl/spi_mem_ctrl_if.sv
// Word-level link between the SPI slave (master side) and spi_mem_ctrl (slave side).
// Optional macro MEM_PARITY_EN adds the par_err signal.
interface spi_mem_ctrl_if;
  logic [9:0] din;
  logic       rx_valid;
  logic [7:0] dout;
  logic       tx_valid;
  logic [7:0] cmd_cnt;
`ifdef MEM_PARITY_EN
  logic       par_err;

  modport master (output din, rx_valid, input dout, tx_valid, cmd_cnt, par_err);
  modport slave  (input din, rx_valid, output dout, tx_valid, cmd_cnt, par_err);
`else
  modport master (output din, rx_valid, input dout, tx_valid, cmd_cnt);
  modport slave  (input din, rx_valid, output dout, tx_valid, cmd_cnt);
`endif
endinterface

// File: rtl/spi_mem_array.sv
// Single-port synchronous storage, MEM_DEPTH x 8 with a registered read port.
// Optional macro MEM_PARITY_EN adds a per-word parity bit, a written flag and a
// registered parity-error pulse aligned with the read data.
module spi_mem_array #(
  parameter int ADDR_SIZE = 8,
  parameter int MEM_DEPTH = 256
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 we,
  input  logic                 re,
  input  logic [ADDR_SIZE-1:0] addr,
  input  logic [7:0]           wdata,
`ifdef MEM_PARITY_EN
  output logic                 par_err,
`endif
  output logic [7:0]           rdata
);

  logic [7:0] mem [MEM_DEPTH];

  // Data array: not reset, contents survive rst_n.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  // Read register: only updates on a read, so the word stays put while it is shifted out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  rdata <= 8'h00;
    else if (re) rdata <= mem[addr];
  end

`ifdef MEM_PARITY_EN
  logic                 par_bits [MEM_DEPTH];
  logic [MEM_DEPTH-1:0] written;

  // Parity bit travels with the data word; no reset, like the data.
  always_ff @(posedge clk) begin
    if (we) par_bits[addr] <= ^wdata;
  end

  // Written flags gate the check so power-up garbage never raises an error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  written <= '0;
    else if (we) written[addr] <= 1'b1;
  end

  // One-cycle error pulse, coincident with the rdata update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) par_err <= 1'b0;
    else        par_err <= re && written[addr] && (par_bits[addr] != ^mem[addr]);
  end
`endif

endmodule

// File: rtl/spi_mem_ctrl.sv
// Command decoder behind the SPI slave: edge-detects rx_valid, keeps auto-incrementing
// write/read address registers, a command counter and the IDLE/RD_HOLD FSM that drives
// tx_valid. Optional macro MEM_PARITY_EN enables per-word parity checking (par_err).
module spi_mem_ctrl
  import spi_mem_pkg::*;
#(
  parameter int ADDR_SIZE = 8,
  parameter int MEM_DEPTH = 256
) (
  input  logic           clk,
  input  logic           rst_n,
  spi_mem_ctrl_if.slave  bus
);

  logic                 rx_valid_q;
  logic                 accept;
  logic [1:0]           opc;
  logic [ADDR_SIZE-1:0] wr_addr, rd_addr, mem_addr;
  logic [7:0]           cnt;
  logic                 we, re;
  state_t               state, nxt_state;

  assign opc      = bus.din[9:8];
  assign accept   = bus.rx_valid && !rx_valid_q;
  assign we       = accept && (opc == CMD_WR_DATA);
  assign re       = accept && (opc == CMD_RD_DATA);
  assign mem_addr = (opc == CMD_RD_DATA) ? rd_addr : wr_addr;

  // Rising-edge detect: a level held for many cycles is one command.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rx_valid_q <= 1'b0;
    else        rx_valid_q <= bus.rx_valid;
  end

  // Address registers; the natural ADDR_SIZE-bit wrap matches MEM_DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_addr <= '0;
      rd_addr <= '0;
    end else if (accept) begin
      case (opc)
        CMD_WR_ADDR: wr_addr <= bus.din[ADDR_SIZE-1:0];
        CMD_WR_DATA: wr_addr <= wr_addr + 1'b1;
        CMD_RD_ADDR: rd_addr <= bus.din[ADDR_SIZE-1:0];
        default:     rd_addr <= rd_addr + 1'b1;
      endcase
    end
  end

  // Accepted-command counter, free-running wrap at 255.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      cnt <= 8'd0;
    else if (accept) cnt <= cnt + 8'd1;
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt_state;
  end

  // Next state: any RD_DATA enters/stays in RD_HOLD, any other command leaves it.
  always_comb begin
    nxt_state = state;
    if (accept) nxt_state = (opc == CMD_RD_DATA) ? RD_HOLD : IDLE;
  end

  assign bus.tx_valid = (state == RD_HOLD);
  assign bus.cmd_cnt  = cnt;

  spi_mem_array #(
    .ADDR_SIZE (ADDR_SIZE),
    .MEM_DEPTH (MEM_DEPTH)
  ) u_array (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (we),
    .re      (re),
    .addr    (mem_addr),
    .wdata   (bus.din[7:0]),
`ifdef MEM_PARITY_EN
    .par_err (bus.par_err),
`endif
    .rdata   (bus.dout)
  );

endmodule

// File: tb/tb_spi_mem_ctrl.sv
// Self-checking bench for spi_mem_ctrl: directed vector table, reset-during-read
// sequence, randomized commands against a behavioural memory model.
// MEM_PARITY_EN adds a corrupted-parity read sequence.
module tb_spi_mem_ctrl;
  import spi_mem_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  spi_mem_ctrl_if bus ();
  spi_mem_ctrl #(.ADDR_SIZE(8), .MEM_DEPTH(256)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int nerr = 0;
  int nchk = 0;

  // behavioural model
  logic [7:0] m_mem [256];
  bit         m_known [256];
  int         m_wa, m_ra, m_cnt;
  logic [7:0] m_dout;
  bit         m_dv, m_tv;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_wa = 0; m_ra = 0; m_cnt = 0; m_dout = 8'h00; m_dv = 1; m_tv = 0;
  endtask

  task automatic model_accept(input logic [1:0] opc, input logic [7:0] pay);
    m_cnt = (m_cnt + 1) % 256;
    m_tv  = (opc == CMD_RD_DATA);
    case (opc)
      CMD_WR_ADDR: m_wa = pay;
      CMD_WR_DATA: begin
        m_mem[m_wa] = pay; m_known[m_wa] = 1; m_wa = (m_wa + 1) % 256;
      end
      CMD_RD_ADDR: m_ra = pay;
      default: begin
        m_dout = m_mem[m_ra]; m_dv = m_known[m_ra]; m_ra = (m_ra + 1) % 256;
      end
    endcase
  endtask

  task automatic model_check(input string tag);
    chk({tag, ".cmd_cnt"}, 32'(bus.cmd_cnt), 32'(m_cnt));
    chk({tag, ".tx_valid"}, 32'(bus.tx_valid), 32'(m_tv));
    if (m_dv) chk({tag, ".dout"}, 32'(bus.dout), 32'(m_dout));
`ifdef MEM_PARITY_EN
    chk({tag, ".par_err"}, 32'(bus.par_err), 32'd0);
`endif
  endtask

  // One command: rx_valid high for 'hold' cycles, then low for one cycle.
  task automatic send(input logic [1:0] opc, input logic [7:0] pay, input int hold);
    @(negedge clk);
    bus.din = {opc, pay};
    bus.rx_valid = 1'b1;
    @(posedge clk);
    model_accept(opc, pay);
    #1 model_check("accept");
    for (int i = 1; i < hold; i++) begin
      @(posedge clk);
      #1 model_check("hold");
    end
    @(negedge clk);
    bus.rx_valid = 1'b0;
    bus.din = 10'($urandom);
    @(posedge clk);
    #1 model_check("idle");
  endtask

  typedef struct {
    logic [1:0] opc;
    logic [7:0] pay;
    int         hold;
    logic [7:0] e_dout;
    logic       e_tv;
    logic [7:0] e_cnt;
  } vec_t;

  vec_t tbl [17];

  initial begin
    tbl[0]  = '{CMD_WR_ADDR, 8'h05, 1,  8'h00, 1'b0, 8'd1};
    tbl[1]  = '{CMD_WR_DATA, 8'hA5, 1,  8'h00, 1'b0, 8'd2};
    tbl[2]  = '{CMD_RD_ADDR, 8'h05, 1,  8'h00, 1'b0, 8'd3};
    tbl[3]  = '{CMD_RD_DATA, 8'h00, 2,  8'hA5, 1'b1, 8'd4};
    tbl[4]  = '{CMD_WR_ADDR, 8'h06, 2,  8'hA5, 1'b0, 8'd5};
    tbl[5]  = '{CMD_WR_DATA, 8'hFF, 12, 8'hA5, 1'b0, 8'd6};
    tbl[6]  = '{CMD_RD_ADDR, 8'h06, 1,  8'hA5, 1'b0, 8'd7};
    tbl[7]  = '{CMD_RD_DATA, 8'h00, 1,  8'hFF, 1'b1, 8'd8};
    tbl[8]  = '{CMD_WR_DATA, 8'h77, 1,  8'hFF, 1'b0, 8'd9};
    tbl[9]  = '{CMD_RD_ADDR, 8'h07, 1,  8'hFF, 1'b0, 8'd10};
    tbl[10] = '{CMD_RD_DATA, 8'h00, 1,  8'h77, 1'b1, 8'd11};
    tbl[11] = '{CMD_WR_ADDR, 8'hFF, 1,  8'h77, 1'b0, 8'd12};
    tbl[12] = '{CMD_WR_DATA, 8'h11, 1,  8'h77, 1'b0, 8'd13};
    tbl[13] = '{CMD_WR_DATA, 8'h22, 1,  8'h77, 1'b0, 8'd14};
    tbl[14] = '{CMD_RD_ADDR, 8'hFF, 1,  8'h77, 1'b0, 8'd15};
    tbl[15] = '{CMD_RD_DATA, 8'h00, 3,  8'h11, 1'b1, 8'd16};
    tbl[16] = '{CMD_RD_DATA, 8'h00, 1,  8'h22, 1'b1, 8'd17};

    for (int i = 0; i < 256; i++) m_known[i] = 0;
    bus.din = 10'h000;
    bus.rx_valid = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset.dout", 32'(bus.dout), 32'h00);
    chk("reset.tx_valid", 32'(bus.tx_valid), 32'd0);
    chk("reset.cmd_cnt", 32'(bus.cmd_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // directed table
    for (int i = 0; i < 17; i++) begin
      send(tbl[i].opc, tbl[i].pay, tbl[i].hold);
      chk($sformatf("vec%0d.dout", i), 32'(bus.dout), 32'(tbl[i].e_dout));
      chk($sformatf("vec%0d.tx_valid", i), 32'(bus.tx_valid), 32'(tbl[i].e_tv));
      chk($sformatf("vec%0d.cmd_cnt", i), 32'(bus.cmd_cnt), 32'(tbl[i].e_cnt));
    end

    // async reset in the middle of RD_HOLD
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid.tx_valid", 32'(bus.tx_valid), 32'd0);
    chk("rst_mid.dout", 32'(bus.dout), 32'h00);
    chk("rst_mid.cmd_cnt", 32'(bus.cmd_cnt), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    send(CMD_RD_DATA, 8'h00, 1);
    chk("post_rst.dout", 32'(bus.dout), 32'h22);
    chk("post_rst.tx_valid", 32'(bus.tx_valid), 32'd1);

    // fill whole memory with a wrapping burst, then random traffic
    send(CMD_WR_ADDR, 8'($urandom), 1);
    for (int i = 0; i < 256; i++) send(CMD_WR_DATA, 8'($urandom), 1);
    for (int i = 0; i < 400; i++)
      send(2'($urandom), 8'($urandom), int'($urandom_range(1, 3)));

`ifdef MEM_PARITY_EN
    send(CMD_WR_ADDR, 8'h07, 1);
    send(CMD_WR_DATA, 8'h3C, 1);
    dut.u_array.par_bits[7] = ~dut.u_array.par_bits[7];
    send(CMD_RD_ADDR, 8'h07, 1);
    @(negedge clk);
    bus.din = {CMD_RD_DATA, 8'h00};
    bus.rx_valid = 1'b1;
    @(posedge clk);
    model_accept(CMD_RD_DATA, 8'h00);
    #1;
    chk("par.dout", 32'(bus.dout), 32'h3C);
    chk("par.tx_valid", 32'(bus.tx_valid), 32'd1);
    chk("par.err_pulse", 32'(bus.par_err), 32'd1);
    @(posedge clk);
    #1 chk("par.err_clear", 32'(bus.par_err), 32'd0);
    @(negedge clk);
    bus.rx_valid = 1'b0;
    send(CMD_RD_ADDR, 8'h08, 1);
    send(CMD_RD_DATA, 8'h00, 1);
`endif

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  // global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "timeout");
  end

endmodule
